aes_inv_cipher: RTL
===================

# aes_inv_cipher

Iterative AES inverse cipher: takes one 128-bit ciphertext block and produces the plaintext using one inverse round per clock. It is the decrypt-side counterpart of the encryption round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey). Round keys come from an external key store through an index/data lookup port, so NR = 10/12/14 covers AES-128/192/256.

## Interface
- NR, 10, number of rounds; legal values are 10, 12 and 14. Any other value is an elaboration error.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext on in_data is valid.
- in_ready  out  1  block can accept a ciphertext.
- in_data  in  128  ciphertext; byte s(0,0) at [127:120], column-major per FIPS-197.
- rk_idx  out  4  index of the round key needed this cycle (0..NR).
- rk_data  in  128  round key rk_idx, returned combinationally by the key store in the same cycle.
- out_valid  out  1  plaintext on out_data is valid.
- out_ready  in  1  consumer accepts the plaintext.
- out_data  out  128  plaintext, same byte order as in_data.

## Operation
- FSM states:
  - IDLE: in_ready = 1, rk_idx = NR. On in_valid: state ← in_data ^ rk_data, rnd ← NR-1, go to ROUND.
  - ROUND: rk_idx = rnd. Each cycle applies InvShiftRows → InvSubBytes → AddRoundKey(rk_data).
    - If rnd ≠ 0, InvMixColumns is then applied and rnd decrements.
    - If rnd = 0, InvMixColumns is skipped, the result loads out_data, and the FSM goes to DONE.
  - DONE: out_valid = 1, rk_idx = NR. On out_ready, go to IDLE.
- in_ready is high only in IDLE. in_valid is ignored in ROUND and DONE; the upstream must hold it.
- out_data and out_valid hold stable in DONE until out_ready is seen, including when out_ready is low for many cycles.
- out_data keeps its last value after the handshake. Only out_valid drops.
- InvMixColumns uses the GF(2^8) matrix {0e,0b,0d,09} with reduction polynomial x^8+x^4+x^3+x+1.
- rnd is 4 bits. It counts NR-1 down to 0 and never wraps.
- Reset in any state, including mid-round, returns to IDLE with out_valid = 0, out_data = 0, the state register = 0 and rnd = 0. A partially processed block is discarded.

## Timing
- Values after reset: in_ready = 1, out_valid = 0, out_data = 0, rk_idx = NR.
- Latency: if the input handshake happens at clock edge E0, out_valid goes high after edge E0+NR.
- ROUND lasts exactly NR cycles.
- Throughput: one block per NR+2 cycles when out_ready is held high (accept cycle, NR round cycles, one DONE cycle).
- In DONE with out_ready = 1, the next edge returns to IDLE. The next block can be accepted in the cycle after that. Accept and deliver never overlap.
- rk_idx is a registered-state decode, so it is glitch-free relative to clk. The key store must return rk_data within the same cycle.
- The critical path is one combinational inverse round plus the round-key XOR.

## Structure
- Package aes_pkg holds:
  - the FSM state enum (IDLE, ROUND, DONE);
  - the inverse S-box as a 256-entry constant function;
  - the xtime and gf_mul helper functions;
  - the legal NR constants.
- Sub-module aes_inv_round: purely combinational inverse round. Inputs: state, round key and a last flag (which bypasses InvMixColumns). Output: the next state. The top level holds only the FSM, counter, registers and handshake logic.

## Test plan
- FIPS-197 App. B, NR = 10:
  - key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 → out_data 3243f6a8885a308d313198a2e0370734;
  - out_valid rises exactly 10 edges after the accept edge.
- FIPS-197 C.1/C.2/C.3, NR = 10/12/14:
  - ciphertexts 69c4e0d86a7b0430d8cdb78070b4c55a, dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089 all → 00112233445566778899aabbccddeeff;
  - rk_idx sequence is NR, NR-1, …, 0.
- Backpressure:
  - hold out_ready = 0 for 20 cycles in DONE → out_data stable, in_ready = 0, and a second in_valid is not accepted;
  - raise out_ready → IDLE one edge later, and the second block is accepted the following cycle.
- Back-to-back: in_valid and out_ready held high for 4 blocks → accept handshakes exactly NR+2 cycles apart, all outputs correct.
- Reset mid-round: assert rst at rnd = 5 → next cycle IDLE, out_valid = 0, out_data = 0. A fresh App. B block then decrypts correctly.
- Reset while in DONE with out_valid = 1 → out_valid = 0 on the next edge, and the block is never handshaken.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// aes_pkg : FSM encoding, inverse S-box and GF(2^8) helpers for AES decrypt
// Rev 1.0
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Entry x sits at bits [2047-8x -: 8]; first row holds entries 0x00..0x0f.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic nr_legal(input int nr);
    return (nr == NR_AES128) || (nr == NR_AES192) || (nr == NR_AES256);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// -----------------------------------------------------------------------------
// aes_inv_round : combinational InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns
// Rev 1.0
// -----------------------------------------------------------------------------
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [7:0] ark [16];
  logic [7:0] mix [16];

  // Byte s(r,c) lives at index 4c+r; InvShiftRows pulls s(r,(c-r) mod 4).
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 4*c + r;
      localparam int SRC = 4*((c - r + 4) % 4) + r;
      assign ark[DST] = inv_sbox(state_in[127-8*SRC -: 8]) ^ round_key[127-8*DST -: 8];
      assign state_out[127-8*DST -: 8] = last ? ark[DST] : mix[DST];
    end

    assign mix[4*c+0] = gf_mul(ark[4*c+0], 8'h0e) ^ gf_mul(ark[4*c+1], 8'h0b) ^
                        gf_mul(ark[4*c+2], 8'h0d) ^ gf_mul(ark[4*c+3], 8'h09);
    assign mix[4*c+1] = gf_mul(ark[4*c+0], 8'h09) ^ gf_mul(ark[4*c+1], 8'h0e) ^
                        gf_mul(ark[4*c+2], 8'h0b) ^ gf_mul(ark[4*c+3], 8'h0d);
    assign mix[4*c+2] = gf_mul(ark[4*c+0], 8'h0d) ^ gf_mul(ark[4*c+1], 8'h09) ^
                        gf_mul(ark[4*c+2], 8'h0e) ^ gf_mul(ark[4*c+3], 8'h0b);
    assign mix[4*c+3] = gf_mul(ark[4*c+0], 8'h0b) ^ gf_mul(ark[4*c+1], 8'h0d) ^
                        gf_mul(ark[4*c+2], 8'h09) ^ gf_mul(ark[4*c+3], 8'h0e);
  end

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher.sv
`default_nettype none
// -----------------------------------------------------------------------------
// aes_inv_cipher : iterative AES decrypt, one inverse round per clock
// Rev 1.0
// -----------------------------------------------------------------------------
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  if (!nr_legal(NR)) begin : g_bad_nr
    $error("aes_inv_cipher: NR must be 10, 12 or 14");
  end

  state_t       state_q, state_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] res_q, res_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         last;
  logic [127:0] round_out;

  assign last = (rnd_q == 4'd0);

  aes_inv_round u_round (
    .state_in  (blk_q),
    .round_key (rk_data),
    .last      (last),
    .state_out (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      res_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    res_d     = res_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = NR_IDX;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d   = in_data ^ rk_data;
          rnd_d   = NR_IDX - 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        rk_idx = rnd_q;
        if (last) begin
          res_d   = round_out;
          state_d = DONE;
        end else begin
          blk_d = round_out;
          rnd_d = rnd_q - 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data = res_q;

endmodule
`default_nettype wire
